uart_rx: RTL

- 8N1 UART receiver; the receive end of the same serial link driven by the team's UART transmitter.
- Synchronises the asynchronous `rx` line and detects start bits.
- Samples each bit at its midpoint and delivers bytes through a one-entry valid/ready holding register.
- Reports framing errors and overruns as one-cycle pulses.
- Sits between the board `ftdi_rx` pin and byte-consuming logic; its default bit timing (one clock per bit) matches the loopback benchmark transmitter.

---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Byte delivery channel of the UART receiver: a one-entry valid/ready handshake.
interface uart_rx_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // Receiver side drives the byte, consumer side drives the acceptance.
    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its midpoint and
// delivers bytes through a one-entry valid/ready holding register. Framing
// errors and overruns are reported as single-cycle pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master out_if,
    output logic      frame_err,
    output logic      overrun,
    output logic      busy
);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             bit_q;
    logic [7:0]             shift_q;
    logic [7:0]             data_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   busy_q;
    logic                   byte_done_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous line through the synchroniser chain; idle level is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // A byte completes on the stop-bit sample edge when the stop bit reads high.
    always_comb begin
        if ((state_q == STOP) && (cnt_q == CNT_LAST) && rx_s) begin
            byte_done_s = 1'b1;
        end else begin
            byte_done_s = 1'b0;
        end
    end

    // Frame state machine plus the holding register and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        busy_q <= 1'b1;
                        // With HALF=0 the detection cycle is already the start midpoint.
                        if (HALF == 0) begin
                            state_q <= DATA;
                            cnt_q   <= CNT_ZERO;
                            bit_q   <= 3'd0;
                        end else begin
                            state_q <= START;
                            cnt_q   <= CNT_ONE;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                            cnt_q   <= CNT_ZERO;
                            bit_q   <= 3'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_q[bit_q] <= rx_s;
                        cnt_q          <= CNT_ZERO;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= CNT_ZERO;
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                BREAK: begin
                    // Wait out a held-low line without further error pulses.
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= CNT_ZERO;
                    busy_q  <= 1'b0;
                end
            endcase

            // Load a finished byte if the holding register is free or draining now.
            if (byte_done_s) begin
                if (!valid_q || out_if.out_ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && out_if.out_ready) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_q;
            end
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign frame_err        = frame_err_q;
    assign overrun          = overrun_q;
    assign busy             = busy_q;
endmodule
